hu_mul_acc_pipe: RTL and testbench

HU_MUL_ACC_PIPE -- requirements
Module: hu_mul_acc_pipe

---
 rtl/hu_arith_pkg.sv | 10 +
 rtl/hu_delay_line.sv | 41 ++++
 rtl/hu_mul_acc_pipe.sv | 141 ++++++++++++++
 tb/tb_hu_mul_acc_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hu_arith_pkg.sv
// Shared constants for the hu_* arithmetic pipelines: legal latency range and
// the fixed stage positions of the operand and multiply registers.
package hu_arith_pkg;

  localparam int unsigned STAGE_IN      = 1;
  localparam int unsigned STAGE_MUL     = 2;
  localparam int unsigned NUM_STAGE_MIN = STAGE_MUL;
  localparam int unsigned NUM_STAGE_MAX = 8;

endpackage

// File: rtl/hu_delay_line.sv
// ce-gated valid/data delay line with synchronous reset; each stage's data
// register only loads on a valid beat, so bubbles leave the output data held.
module hu_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    assign out_valid = in_valid;
    assign dout      = din;
  end else begin : g_regs
    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= '0;
        for (int i = 0; i < int'(DEPTH); i++) d_q[i] <= '0;
      end else if (ce) begin
        v_q[0] <= in_valid;
        if (in_valid) d_q[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) begin
          v_q[i] <= v_q[i-1];
          if (v_q[i-1]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign out_valid = v_q[DEPTH-1];
    assign dout      = d_q[DEPTH-1];
  end

endmodule

// File: rtl/hu_mul_acc_pipe.sv
// Pipelined multiplier with optional running-sum accumulator.
// Define HU_MAC_ACC_EN to add the acc_clr port and the accumulator.
module hu_mul_acc_pipe
  import hu_arith_pkg::*;
#(
  parameter int unsigned A_WIDTH     = 16,
  parameter int unsigned B_WIDTH     = 8,
  parameter int unsigned P_WIDTH     = 24,
  parameter int unsigned NUM_STAGE   = 4,
  parameter int unsigned SIGNED_MODE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
`ifdef HU_MAC_ACC_EN
  input  logic               acc_clr,
`endif
  output logic [P_WIDTH-1:0] dout,
  output logic               out_valid
);

  localparam int unsigned FullWidth = A_WIDTH + B_WIDTH;
  localparam int unsigned DlyDepth  = NUM_STAGE - STAGE_MUL;
`ifdef HU_MAC_ACC_EN
  localparam int unsigned DlyWidth  = P_WIDTH + 1;
`else
  localparam int unsigned DlyWidth  = P_WIDTH;
`endif

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_num_stage
    $error("hu_mul_acc_pipe: NUM_STAGE out of range");
  end

  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  logic                 v1_q, v2_q;
  logic [FullWidth-1:0] a_ext, b_ext, prod_full;
  logic [P_WIDTH-1:0]   prod_rs, p2_q;
  logic [DlyWidth-1:0]  dly_in, fin_d;
  logic                 fin_v;

  always_comb begin
    if (SIGNED_MODE != 0) begin
      a_ext = {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q};
      b_ext = {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q};
    end else begin
      a_ext = {{B_WIDTH{1'b0}}, a_q};
      b_ext = {{A_WIDTH{1'b0}}, b_q};
    end
    // Low FullWidth bits of the extended product are the exact product either way.
    prod_full = a_ext * b_ext;
  end

  if (P_WIDTH <= FullWidth) begin : g_trunc
    assign prod_rs = prod_full[P_WIDTH-1:0];
  end else begin : g_extend
    logic ext_bit;
    assign ext_bit = (SIGNED_MODE != 0) ? prod_full[FullWidth-1] : 1'b0;
    assign prod_rs = {{(P_WIDTH - FullWidth){ext_bit}}, prod_full};
  end

`ifdef HU_MAC_ACC_EN
  logic c1_q, c2_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
      p2_q <= '0;
      v2_q <= 1'b0;
`ifdef HU_MAC_ACC_EN
      c1_q <= 1'b0;
      c2_q <= 1'b0;
`endif
    end else if (ce) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (in_valid) begin
        a_q <= din0;
        b_q <= din1;
`ifdef HU_MAC_ACC_EN
        c1_q <= acc_clr;
`endif
      end
      if (v1_q) begin
        p2_q <= prod_rs;
`ifdef HU_MAC_ACC_EN
        c2_q <= c1_q;
`endif
      end
    end
  end

`ifdef HU_MAC_ACC_EN
  assign dly_in = {c2_q, p2_q};
`else
  assign dly_in = p2_q;
`endif

  hu_delay_line #(
    .WIDTH (DlyWidth),
    .DEPTH (DlyDepth)
  ) u_delay_line (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (v2_q),
    .din       (dly_in),
    .out_valid (fin_v),
    .dout      (fin_d)
  );

  assign out_valid = fin_v;

`ifdef HU_MAC_ACC_EN
  logic [P_WIDTH-1:0] acc_q, acc_sum;

  // dout shows the new sum during the final-stage valid cycle; acc_q commits it
  // at the ce edge that ends that cycle.
  always_comb begin
    acc_sum = (fin_d[P_WIDTH] ? '0 : acc_q) + fin_d[P_WIDTH-1:0];
    dout    = fin_v ? acc_sum : acc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (ce && fin_v) begin
      acc_q <= acc_sum;
    end
  end
`else
  assign dout = fin_d;
`endif

endmodule

// File: tb/tb_hu_mul_acc_pipe.sv
// Randomised and directed checks of hu_mul_acc_pipe (unsigned and signed
// instances) against a transaction-level model; honours HU_MAC_ACC_EN.
module tb_hu_mul_acc_pipe;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] din0 = '0;
  logic [7:0]  din1 = '0;
  logic        acc_clr = 1'b0;
  logic [23:0] dout_u, dout_s;
  logic        ov_u, ov_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hu_mul_acc_pipe u_dut_u (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .din0      (din0),
    .din1      (din1),
`ifdef HU_MAC_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .dout      (dout_u),
    .out_valid (ov_u)
  );

  hu_mul_acc_pipe #(
    .SIGNED_MODE (1)
  ) u_dut_s (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .din0      (din0),
    .din1      (din1),
`ifdef HU_MAC_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .dout      (dout_s),
    .out_valid (ov_s)
  );

  // Model: each accepted pair becomes a pending result due NS-1 ce edges later.
  typedef struct {
    int          due;
    logic [23:0] pu;
    logic [23:0] ps;
    logic        clr;
  } pend_t;

  pend_t       pend_q[$];
  int          ce_cnt = 0;
  logic        exp_v = 1'b0;
  logic [23:0] last_u = '0, last_s = '0, acc_u = '0, acc_s = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d (0x%0h), expected %0d (0x%0h)", tag, $time, got, got,
               exp, exp);
    end
  endtask

  task automatic tick(input logic c, input logic v, input logic [15:0] a, input logic [7:0] b,
                      input logic clr, input logic rst);
    pend_t  e;
    longint fu, fs;
    ce = c; in_valid = v; din0 = a; din1 = b; acc_clr = clr; reset = rst;
    @(posedge clk);
    if (rst) begin
      pend_q.delete();
      exp_v = 1'b0; last_u = '0; last_s = '0; acc_u = '0; acc_s = '0;
    end else if (c) begin
      ce_cnt++;
      if (v) begin
        fu = longint'(a) * longint'(b);
        fs = longint'($signed(a)) * longint'($signed(b));
        e.due = ce_cnt + NS - 1;
        e.pu  = fu[23:0];
        e.ps  = fs[23:0];
        e.clr = clr;
        pend_q.push_back(e);
      end
      exp_v = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due == ce_cnt) begin
        e = pend_q.pop_front();
        exp_v = 1'b1;
`ifdef HU_MAC_ACC_EN
        acc_u = (e.clr ? 24'd0 : acc_u) + e.pu;
        acc_s = (e.clr ? 24'd0 : acc_s) + e.ps;
        last_u = acc_u;
        last_s = acc_s;
`else
        last_u = e.pu;
        last_s = e.ps;
`endif
      end
    end
    #1;
    check("ov_u", 64'(ov_u), 64'(exp_v));
    check("dout_u", 64'(dout_u), 64'(last_u));
    check("ov_s", 64'(ov_s), 64'(exp_v));
    check("dout_s", 64'(dout_s), 64'(last_s));
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic rst_pulse();
    tick(1'b1, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_pulse();
    rst_pulse();
    check("reset_dout", 64'(dout_u), 64'd0);
    check("reset_ov", 64'(ov_u), 64'd0);

    // Single pair, four-cycle latency.
    tick(1'b1, 1'b1, 16'd1000, 8'd200, 1'b1, 1'b0);
    idle(); idle(); idle();
    check("lat_dout", 64'(dout_u), 64'd200000);
    check("lat_ov", 64'(ov_u), 64'd1);
    idle();
    check("lat_ov_next", 64'(ov_u), 64'd0);
    check("lat_hold", 64'(dout_u), 64'd200000);

    // Negative operand: signed vs unsigned interpretation.
    tick(1'b1, 1'b1, 16'hFFFD, 8'd5, 1'b1, 1'b0);
    idle(); idle(); idle();
    check("sgn_u", 64'(dout_u), 64'd327665);
    check("sgn_s", 64'(dout_s), 64'hFFFFF1);

    // Stall for three cycles mid-flight; inputs during stall are ignored.
    tick(1'b1, 1'b1, 16'd7, 8'd9, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 16'd1234, 8'd56, 1'b0, 1'b0);
      check("stall_ov", 64'(ov_u), 64'd0);
    end
    idle(); idle();
    check("stall_dout", 64'(dout_u), 64'd63);
    check("stall_ov_out", 64'(ov_u), 64'd1);
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
      check("stall_hold_ov", 64'(ov_u), 64'd1);
      check("stall_hold_dout", 64'(dout_u), 64'd63);
    end
    idle();
    check("stall_ov_drop", 64'(ov_u), 64'd0);

`ifdef HU_MAC_ACC_EN
    begin
      logic [15:0] aa [4];
      logic [7:0]  bb [4];
      logic        cc [4];
      logic [23:0] ee [4];
      aa = '{16'd10, 16'd5, 16'd1, 16'd7};
      bb = '{8'd2, 8'd4, 8'd1, 8'd3};
      cc = '{1'b1, 1'b0, 1'b0, 1'b1};
      ee = '{24'd20, 24'd40, 24'd41, 24'd21};
      rst_pulse();
      for (int k = 0; k < 7; k++) begin
        if (k < 4) tick(1'b1, 1'b1, aa[k], bb[k], cc[k], 1'b0);
        else idle();
        if (k >= 3) check("acc_seq", 64'(dout_u), 64'(ee[k-3]));
      end
      rst_pulse();
      tick(1'b1, 1'b1, 16'd65535, 8'd255, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 16'd65535, 8'd255, 1'b0, 1'b0);
      idle(); idle();
      check("acc_wrap0", 64'(dout_u), 64'd16711425);
      idle();
      check("acc_wrap1", 64'(dout_u), 64'd16645634);
    end
`endif

    // Reset right after three pairs: nothing may emerge.
    rst_pulse();
    tick(1'b1, 1'b1, 16'd11, 8'd3, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 16'd12, 8'd4, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 16'd13, 8'd5, 1'b0, 1'b0);
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      idle();
      check("flush_ov", 64'(ov_u), 64'd0);
      check("flush_dout", 64'(dout_u), 64'd0);
    end

    // Random traffic with stalls, bubbles, clears and rare resets.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 4) != 0, ($urandom % 5) < 3, 16'($urandom), 8'($urandom),
           ($urandom % 6) == 0, ($urandom % 100) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
